// File: rtl/fixed_requant_stream.sv
// Streaming requantiser: wide signed fixed-point lanes -> narrow signed fixed-point with round-half-up and saturation.
// Optional saturation event counter enabled by defining FIXED_REQUANT_SAT_COUNT_EN.
module fixed_requant_stream #(
  parameter int DATA_IN_0_PRECISION_0      = 16,
  parameter int DATA_IN_0_PRECISION_1      = 8,
  parameter int DATA_OUT_0_PRECISION_0     = 8,
  parameter int DATA_OUT_0_PRECISION_1     = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4
) (
  input  logic                                                          clk,
  input  logic                                                          rst_n,
  input  logic [DATA_IN_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0-1:0]  data_in_0,
  input  logic                                                          data_in_0_valid,
  output logic                                                          data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0-1:0] data_out_0,
  output logic                                                          data_out_0_valid,
  input  logic                                                          data_out_0_ready,
  output logic [15:0]                                                   sat_count
);

  localparam int IN_W  = DATA_IN_0_PRECISION_0;
  localparam int IN_F  = DATA_IN_0_PRECISION_1;
  localparam int OUT_W = DATA_OUT_0_PRECISION_0;
  localparam int OUT_F = DATA_OUT_0_PRECISION_1;
  localparam int P     = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int SH    = IN_F - OUT_F;
  localparam int RW    = IN_W + 1;

  localparam logic signed [RW-1:0] MAXV = RW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  if (IN_F < OUT_F || OUT_W > IN_W) begin : g_bad_cfg
    $error("fixed_requant_stream: need IN_F >= OUT_F and OUT_W <= IN_W");
  end

  // Handshake: a transfer happens on a side when its valid and ready are both
  // high at the clock edge. The whole pipe advances when the output register is
  // empty or being drained, so input ready never depends on input valid.
  logic en;
  assign en              = !data_out_0_valid || data_out_0_ready;
  assign data_in_0_ready = en;

  logic signed [RW-1:0] rnd  [P];
  logic signed [RW-1:0] s1_r [P];
  logic                 s1_valid;
  logic [OUT_W*P-1:0]   sat_data;

  for (genvar g = 0; g < P; g++) begin : g_lane
    logic signed [IN_W-1:0] x;
    assign x = data_in_0[g*IN_W +: IN_W];
    if (SH > 0) begin : g_rnd
      logic signed [RW-1:0] t;
      // One guard bit keeps the half-LSB add from wrapping at the top of range.
      assign t      = {x[IN_W-1], x} + (RW'(1) << (SH - 1));
      assign rnd[g] = t >>> SH;
    end else begin : g_pass
      assign rnd[g] = {x[IN_W-1], x};
    end
  end

  always_comb begin
    sat_data = '0;
    for (int i = 0; i < P; i++) begin
      if (s1_r[i] > MAXV) begin
        sat_data[i*OUT_W +: OUT_W] = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (s1_r[i] < MINV) begin
        sat_data[i*OUT_W +: OUT_W] = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        sat_data[i*OUT_W +: OUT_W] = s1_r[i][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid         <= 1'b0;
      data_out_0_valid <= 1'b0;
      data_out_0       <= '0;
      for (int i = 0; i < P; i++) s1_r[i] <= '0;
    end else if (en) begin
      s1_valid         <= data_in_0_valid;
      data_out_0_valid <= s1_valid;
      data_out_0       <= sat_data;
      for (int i = 0; i < P; i++) s1_r[i] <= rnd[i];
    end
  end

`ifdef FIXED_REQUANT_SAT_COUNT_EN
  logic [P-1:0]  sat_flag;
  logic [16:0]   cnt_sum;
  logic [15:0]   cnt_q;

  always_comb begin
    sat_flag = '0;
    cnt_sum  = {1'b0, cnt_q};
    for (int i = 0; i < P; i++) begin
      sat_flag[i] = (s1_r[i] > MAXV) || (s1_r[i] < MINV);
      cnt_sum     = cnt_sum + 17'(sat_flag[i]);
    end
  end

  // Counts only vectors entering the output register; pins at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en && s1_valid) begin
      cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign sat_count = cnt_q;
`else
  assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fixed_requant_stream.sv
// Directed bench for fixed_requant_stream: vector table, multi-lane, throughput, backpressure, mid-stream reset.
module tb_fixed_requant_stream;

  logic        clk;
  logic        rst_n;
  logic [63:0] data_in_0;
  logic        data_in_0_valid;
  logic        data_in_0_ready;
  logic [31:0] data_out_0;
  logic        data_out_0_valid;
  logic        data_out_0_ready;
  logic [15:0] sat_count;

`ifdef FIXED_REQUANT_SAT_COUNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  fixed_requant_stream dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready),
    .sat_count        (sat_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_sat = 16'h0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] din;
    logic [7:0]  dout;
    logic        sat;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: round half up at 4 fractional bits, saturate to signed 8 bits.
  function automatic logic [8:0] model(input logic [15:0] x);
    int v;
    int r;
    v = int'(signed'(x));
    r = (v + 8) >>> 4;
    if (r > 127) return {1'b1, 8'h7F};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, r[7:0]};
  endfunction

  function automatic logic [63:0] vec_of(input int k);
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(k * 16'h0123 + i * 16'h2222 - 16'h3000);
    return v;
  endfunction

  task automatic exp_vec(input logic [63:0] v, output logic [31:0] d, output int ns);
    logic [8:0] m;
    ns = 0;
    for (int i = 0; i < 4; i++) begin
      m = model(v[i*16 +: 16]);
      d[i*8 +: 8] = m[7:0];
      ns += int'(m[8]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one isolated vector with ready held high, checking exact latency
  task automatic send_single(input string nm, input logic [63:0] d, input logic [31:0] exp, input int nsat);
    data_in_0        = d;
    data_in_0_valid  = 1'b1;
    data_out_0_ready = 1'b1;
    tick();
    data_in_0_valid = 1'b0;
    data_in_0       = '0;
    check({nm, "_lat1_valid"}, {31'h0, data_out_0_valid}, 32'h0);
    tick();
    if (SAT_EN) exp_sat = exp_sat + 16'(nsat);
    check({nm, "_valid"}, {31'h0, data_out_0_valid}, 32'h1);
    check({nm, "_data"}, data_out_0, exp);
    check({nm, "_satcnt"}, {16'h0, sat_count}, {16'h0, exp_sat});
    tick();
    check({nm, "_drain"}, {31'h0, data_out_0_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] held;
    logic [31:0] got_exp;
    int          ns;
    int          sent;
    int          got;
    int          cyc;
    logic        stalled;

    tbl[0]  = '{16'h0123, 8'h12, 1'b0};
    tbl[1]  = '{16'h0008, 8'h01, 1'b0};
    tbl[2]  = '{16'h0007, 8'h00, 1'b0};
    tbl[3]  = '{16'hFFF8, 8'h00, 1'b0};
    tbl[4]  = '{16'hFFF7, 8'hFF, 1'b0};
    tbl[5]  = '{16'hFFE8, 8'hFF, 1'b0};
    tbl[6]  = '{16'hFFE7, 8'hFE, 1'b0};
    tbl[7]  = '{16'h7FFF, 8'h7F, 1'b1};
    tbl[8]  = '{16'h8000, 8'h80, 1'b1};
    tbl[9]  = '{16'h07F8, 8'h7F, 1'b1};
    tbl[10] = '{16'h07F7, 8'h7F, 1'b0};
    tbl[11] = '{16'h0000, 8'h00, 1'b0};
    tbl[12] = '{16'h07E8, 8'h7F, 1'b0};

    rst_n            = 1'b0;
    data_in_0        = '0;
    data_in_0_valid  = 1'b0;
    data_out_0_ready = 1'b1;
    #12;
    check("rst_valid", {31'h0, data_out_0_valid}, 32'h0);
    check("rst_data", data_out_0, 32'h0);
    check("rst_satcnt", {16'h0, sat_count}, 32'h0);
    check("rst_in_ready", {31'h0, data_in_0_ready}, 32'h1);
    rst_n = 1'b1;
    tick();

    // table-driven single-lane vectors
    for (int k = 0; k < 13; k++) begin
      send_single($sformatf("tbl%0d", k), {48'h0, tbl[k].din}, {24'h0, tbl[k].dout}, int'(tbl[k].sat));
    end

    send_single("multilane", 64'h8000_FFF0_0010_7FFF, 32'h80FF_017F, 2);

    // throughput with ready held high: one vector per cycle after the fill
    data_out_0_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      data_in_0       = vec_of(c);
      data_in_0_valid = (c < 8);
      if (c < 8) begin
        exp_vec(vec_of(c), d, ns);
        if (SAT_EN) exp_sat = exp_sat + 16'(ns);
      end
      @(negedge clk);
      check($sformatf("tp_valid%0d", c), {31'h0, data_out_0_valid}, {31'h0, (c >= 2 && c < 10)});
      if (c >= 2 && c < 10) begin
        exp_vec(vec_of(c - 2), d, ns);
        check($sformatf("tp_data%0d", c), data_out_0, d);
      end
      tick();
    end
    data_in_0_valid = 1'b0;
    check("tp_satcnt", {16'h0, sat_count}, {16'h0, exp_sat});

    // random backpressure with scoreboard and stall-stability checks
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got < 20 && cyc < 400) begin
      data_in_0_valid  = (sent < 20);
      data_in_0        = vec_of(100 + sent);
      data_out_0_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled && data_out_0_valid) check("bp_stable", data_out_0, held);
      if (data_out_0_valid && data_out_0_ready) begin
        if (exp_q.size() == 0) begin
          check("bp_unexpected_out", data_out_0, 32'hDEAD_BEEF);
        end else begin
          got_exp = exp_q.pop_front();
          check("bp_data", data_out_0, got_exp);
        end
        got++;
      end
      if (data_in_0_valid && data_in_0_ready) begin
        exp_vec(vec_of(100 + sent), d, ns);
        exp_q.push_back(d);
        if (SAT_EN) exp_sat = exp_sat + 16'(ns);
        sent++;
      end
      stalled = data_out_0_valid && !data_out_0_ready;
      held    = data_out_0;
      tick();
      cyc++;
    end
    data_in_0_valid  = 1'b0;
    data_out_0_ready = 1'b1;
    check("bp_count", got, 20);
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_satcnt", {16'h0, sat_count}, {16'h0, exp_sat});
    tick();
    tick();
    check("bp_idle", {31'h0, data_out_0_valid}, 32'h0);

    // mid-stream reset with two saturating vectors in flight
    data_out_0_ready = 1'b1;
    data_in_0        = 64'h7FFF_7FFF_7FFF_7FFF;
    data_in_0_valid  = 1'b1;
    tick();
    data_in_0 = 64'h8000_8000_8000_8000;
    tick();
    data_in_0_valid = 1'b0;
    check("pre_rst_valid", {31'h0, data_out_0_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    exp_sat = 16'h0;
    check("mrst_valid", {31'h0, data_out_0_valid}, 32'h0);
    check("mrst_data", data_out_0, 32'h0);
    check("mrst_satcnt", {16'h0, sat_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("mrst_no_stale%0d", c), {31'h0, data_out_0_valid}, 32'h0);
      tick();
    end
    send_single("post_rst", 64'h0000_0010_0123_FFE7, 32'h0001_12FE, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
